// File: rtl/axi_outstanding_watchdog.sv
// axi_outstanding_watchdog
//   Passive monitor on the downstream AXI4 master link of the atomics adapter.
//   Counts outstanding write bursts (AW accepted, B pending) and read bursts
//   (AR accepted, last R beat pending), and raises a sticky interrupt when
//   outstanding traffic makes no progress for TIMEOUT_CYCLES cycles.
//
// Optional feature macro: AXI_MON_RESP_ERR_CNT_EN
//   When defined, resp_err_cnt counts B and R beats whose resp[1] is set
//   (SLVERR/DECERR), saturating at 16'hFFFF. When undefined it is tied to 0.
//
// Ports:
//   CLK, areset         clock, asynchronous active-high reset
//   mon_*               handshake taps from the AXI link (inputs only)
//   clear               pulse: clears sticky flags, timer and resp_err_cnt
//   wr_outstanding      outstanding write bursts
//   rd_outstanding      outstanding read bursts
//   timeout_irq         sticky no-progress timeout
//   timeout_is_write    writes were outstanding when the timeout fired
//   overflow_err        sticky: AW/AR accepted with count at MAX_OUTSTANDING
//   underflow_err       sticky: B / last R accepted with count at 0
//   resp_err_cnt        error response count (optional feature)

module axi_outstanding_watchdog #(
    parameter int unsigned MAX_OUTSTANDING = 16,
    parameter int unsigned CNT_WIDTH       = 5,
    parameter int unsigned TIMER_WIDTH     = 16,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic                 CLK,
    input  logic                 areset,
    input  logic                 mon_awvalid,
    input  logic                 mon_awready,
    input  logic                 mon_wvalid,
    input  logic                 mon_wready,
    input  logic                 mon_bvalid,
    input  logic                 mon_bready,
    input  logic [1:0]           mon_bresp,
    input  logic                 mon_arvalid,
    input  logic                 mon_arready,
    input  logic                 mon_rvalid,
    input  logic                 mon_rready,
    input  logic                 mon_rlast,
    input  logic [1:0]           mon_rresp,
    input  logic                 clear,
    output logic [CNT_WIDTH-1:0] wr_outstanding,
    output logic [CNT_WIDTH-1:0] rd_outstanding,
    output logic                 timeout_irq,
    output logic                 timeout_is_write,
    output logic                 overflow_err,
    output logic                 underflow_err,
    output logic [15:0]          resp_err_cnt
);

    localparam logic [CNT_WIDTH-1:0]   MAX_CNT    = CNT_WIDTH'(MAX_OUTSTANDING);
    localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        TIMEOUT = 2'd2
    } state_t;

    state_t                 state, state_next;
    logic [TIMER_WIDTH-1:0] timer, timer_next;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, rl_hs, progress;

    assign aw_hs    = mon_awvalid & mon_awready;
    assign w_hs     = mon_wvalid  & mon_wready;
    assign b_hs     = mon_bvalid  & mon_bready;
    assign ar_hs    = mon_arvalid & mon_arready;
    assign r_hs     = mon_rvalid  & mon_rready;
    assign rl_hs    = r_hs & mon_rlast;
    assign progress = aw_hs | w_hs | b_hs | ar_hs | r_hs;

    // ------------------------------------------------------------------
    // Outstanding counters: a simultaneous accept and completion cancel
    // out without touching the error flags.
    // ------------------------------------------------------------------
    logic [CNT_WIDTH-1:0] wr_next, rd_next;
    logic                 wr_ovf, wr_udf, rd_ovf, rd_udf;
    logic                 any_next;

    always_comb begin
        wr_next = wr_outstanding;
        wr_ovf  = 1'b0;
        wr_udf  = 1'b0;
        if (aw_hs && !b_hs) begin
            if (wr_outstanding == MAX_CNT) wr_ovf  = 1'b1;
            else                           wr_next = wr_outstanding + 1'b1;
        end else if (b_hs && !aw_hs) begin
            if (wr_outstanding == '0) wr_udf  = 1'b1;
            else                      wr_next = wr_outstanding - 1'b1;
        end
    end

    always_comb begin
        rd_next = rd_outstanding;
        rd_ovf  = 1'b0;
        rd_udf  = 1'b0;
        if (ar_hs && !rl_hs) begin
            if (rd_outstanding == MAX_CNT) rd_ovf  = 1'b1;
            else                           rd_next = rd_outstanding + 1'b1;
        end else if (rl_hs && !ar_hs) begin
            if (rd_outstanding == '0) rd_udf  = 1'b1;
            else                      rd_next = rd_outstanding - 1'b1;
        end
    end

    assign any_next = (wr_next != '0) || (rd_next != '0);

    // ------------------------------------------------------------------
    // Stall FSM, evaluated on the post-update counts.
    // ------------------------------------------------------------------
    logic fire;

    always_comb begin
        state_next = state;
        timer_next = timer;
        fire       = 1'b0;
        unique case (state)
            IDLE: begin
                timer_next = '0;
                if (any_next) state_next = BUSY;
            end
            BUSY: begin
                if (!any_next) begin
                    state_next = IDLE;
                    timer_next = '0;
                end else if (progress) begin
                    timer_next = '0;
                end else if (timer == TIMER_LAST) begin
                    state_next = TIMEOUT;
                    fire       = 1'b1;
                end else begin
                    timer_next = timer + 1'b1;
                end
            end
            TIMEOUT: begin
                // frozen until clear
            end
            default: begin
                state_next = IDLE;
                timer_next = '0;
            end
        endcase
        // clear wins over a timeout firing in the same cycle
        if (clear) begin
            state_next = any_next ? BUSY : IDLE;
            timer_next = '0;
            fire       = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge areset) begin
        if (areset) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            state <= state_next;
            timer <= timer_next;
        end
    end

    always_ff @(posedge CLK or posedge areset) begin
        if (areset) begin
            wr_outstanding   <= '0;
            rd_outstanding   <= '0;
            timeout_irq      <= 1'b0;
            timeout_is_write <= 1'b0;
            overflow_err     <= 1'b0;
            underflow_err    <= 1'b0;
        end else begin
            wr_outstanding <= wr_next;
            rd_outstanding <= rd_next;
            if (clear) begin
                timeout_irq      <= 1'b0;
                timeout_is_write <= 1'b0;
                overflow_err     <= 1'b0;
                underflow_err    <= 1'b0;
            end else begin
                if (fire) begin
                    timeout_irq      <= 1'b1;
                    timeout_is_write <= (wr_next != '0);
                end
                if (wr_ovf || rd_ovf) overflow_err  <= 1'b1;
                if (wr_udf || rd_udf) underflow_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Error response counter (optional)
    // ------------------------------------------------------------------
`ifdef AXI_MON_RESP_ERR_CNT_EN
    logic [1:0]  err_inc;
    logic [16:0] err_sum;
    logic        unused_resp;

    assign err_inc     = {1'b0, b_hs & mon_bresp[1]} + {1'b0, r_hs & mon_rresp[1]};
    assign err_sum     = {1'b0, resp_err_cnt} + {15'd0, err_inc};
    assign unused_resp = mon_bresp[0] ^ mon_rresp[0];

    always_ff @(posedge CLK or posedge areset) begin
        if (areset)           resp_err_cnt <= '0;
        else if (clear)       resp_err_cnt <= '0;
        else if (err_sum[16]) resp_err_cnt <= '1;
        else                  resp_err_cnt <= err_sum[15:0];
    end
`else
    logic unused_resp;

    assign unused_resp  = ^{mon_bresp, mon_rresp};
    assign resp_err_cnt = '0;
`endif

endmodule
